// File: rtl/nano_dsi_data_rx.sv
// nano_dsi_data_rx: single-lane DSI-style HS data receiver.
// Detects start of transmission on the LP line and hunts the 0xB8 sync byte.
// Bytes are deserialised LSB first, and the HS trail is stripped using the last
// data/trail transition. Bytes leave on a valid/last stream with no backpressure.
module nano_dsi_data_rx #(
  parameter int HOLD_DEPTH   = 4,
  parameter int SYNC_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lp_in,
  input  logic       hs_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_last,
  output logic       rx_sot,
  output logic       rx_err,
  output logic       rx_busy
);

  // Holdback occupancy needs to represent 0..HOLD_DEPTH inclusive.
  localparam int CW = $clog2(HOLD_DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH   = CW'(HOLD_DEPTH);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] C_ZERO    = CW'(0);
  localparam logic [15:0]   C_TIMEOUT = 16'(SYNC_TIMEOUT);
  localparam logic [7:0]    C_SYNC    = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SYNC_HUNT = 3'd1,
    ST_DATA      = 3'd2,
    ST_FLUSH     = 3'd3,
    ST_WAIT_LP   = 3'd4
  } state_t;

  state_t        r_state;
  logic [7:0]    r_sr;
  logic [15:0]   r_timer;
  logic [7:0]    r_deser;
  logic [2:0]    r_bit_cnt;
  logic [15:0]   r_bit_pos;
  logic [15:0]   r_edge_pos;
  logic          r_prev_bit;
  logic [7:0]    r_hold [HOLD_DEPTH];
  logic [CW-1:0] r_count;
  logic [15:0]   r_emitted;
  logic [CW-1:0] r_flush_n;
  logic          r_flush_err;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_last;
  logic          r_sot;
  logic          r_err;
  logic          r_busy;

  logic [7:0]    w_sr_next;
  logic [15:0]   w_timer_next;
  logic          w_match;
  logic          w_timeout;
  logic [7:0]    w_byte;
  logic          w_byte_done;
  logic          w_full;
  logic [15:0]   w_bit_pos_inc;
  logic [15:0]   w_emitted_inc;
  logic [15:0]   w_total;
  logic [15:0]   w_avail;
  logic [15:0]   w_count_ext;
  logic [CW-1:0] w_flush_n;
  logic          w_misaligned;
  logic          w_empty;

  // Next-value helpers for sync hunt, deserialiser and end-of-burst trimming.
  always_comb begin
    w_sr_next     = {hs_in, r_sr[7:1]};
    w_timer_next  = r_timer + 16'd1;
    w_match       = (w_sr_next == C_SYNC);
    w_timeout     = (w_timer_next >= C_TIMEOUT);
    w_byte        = {hs_in, r_deser[7:1]};
    w_byte_done   = (r_bit_cnt == 3'd7);
    w_full        = (r_count == C_DEPTH);
    w_bit_pos_inc = (r_bit_pos == 16'hFFFF) ? r_bit_pos : (r_bit_pos + 16'd1);
    w_emitted_inc = (r_emitted == 16'hFFFF) ? r_emitted : (r_emitted + 16'd1);
    // Bytes strictly before the first trail bit are payload.
    w_total       = {3'b000, r_edge_pos[15:3]};
    w_count_ext   = {{(16-CW){1'b0}}, r_count};
    if (w_total > r_emitted) begin
      w_avail = w_total - r_emitted;
    end else begin
      w_avail = 16'd0;
    end
    if (w_avail > w_count_ext) begin
      w_flush_n = r_count;
    end else begin
      w_flush_n = w_avail[CW-1:0];
    end
    w_misaligned  = (r_edge_pos[2:0] != 3'd0);
    w_empty       = (r_edge_pos == 16'd0) && (r_emitted == 16'd0);
  end

  // Receiver FSM with holdback FIFO and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sr        <= 8'h00;
      r_timer     <= 16'd0;
      r_deser     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_bit_pos   <= 16'd0;
      r_edge_pos  <= 16'd0;
      r_prev_bit  <= 1'b1;
      r_count     <= C_ZERO;
      r_emitted   <= 16'd0;
      r_flush_n   <= C_ZERO;
      r_flush_err <= 1'b0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_sot       <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < HOLD_DEPTH; i++) begin
        r_hold[i] <= 8'h00;
      end
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_sot   <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!lp_in) begin
            r_state <= ST_SYNC_HUNT;
            r_busy  <= 1'b1;
            r_sr    <= 8'h00;
            r_timer <= 16'd0;
          end else begin
            r_busy  <= 1'b0;
          end
        end

        ST_SYNC_HUNT: begin
          if (lp_in) begin
            // Stop state before sync: also wins over a same-cycle match.
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_sr    <= w_sr_next;
            r_timer <= w_timer_next;
            if (w_match) begin
              r_sot      <= 1'b1;
              r_state    <= ST_DATA;
              r_bit_cnt  <= 3'd0;
              r_bit_pos  <= 16'd0;
              r_edge_pos <= 16'd0;
              r_prev_bit <= 1'b1;
              r_deser    <= 8'h00;
              r_count    <= C_ZERO;
              r_emitted  <= 16'd0;
            end else if (w_timeout) begin
              r_err   <= 1'b1;
              r_state <= ST_WAIT_LP;
            end else begin
              r_state <= ST_SYNC_HUNT;
            end
          end
        end

        ST_DATA: begin
          if (lp_in) begin
            // Partial byte is dropped; decide now how many held bytes are payload.
            r_state     <= ST_FLUSH;
            r_flush_n   <= w_misaligned ? C_ZERO : w_flush_n;
            r_flush_err <= w_misaligned || w_empty;
          end else begin
            r_deser    <= w_byte;
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_bit_pos  <= w_bit_pos_inc;
            r_prev_bit <= hs_in;
            if (hs_in != r_prev_bit) begin
              r_edge_pos <= r_bit_pos;
            end
            if (w_byte_done) begin
              if (w_full) begin
                // Oldest byte is now far enough from any trail: release it.
                r_valid   <= 1'b1;
                r_data    <= r_hold[0];
                r_emitted <= w_emitted_inc;
                for (int i = 0; i < HOLD_DEPTH - 1; i++) begin
                  r_hold[i] <= r_hold[i+1];
                end
                r_hold[HOLD_DEPTH-1] <= w_byte;
              end else begin
                for (int i = 0; i < HOLD_DEPTH; i++) begin
                  if (r_count == CW'(i)) begin
                    r_hold[i] <= w_byte;
                  end
                end
                r_count <= r_count + C_ONE;
              end
            end
          end
        end

        ST_FLUSH: begin
          r_err       <= r_flush_err;
          r_flush_err <= 1'b0;
          if (r_flush_n != C_ZERO) begin
            r_valid   <= 1'b1;
            r_data    <= r_hold[0];
            r_last    <= (r_flush_n == C_ONE);
            r_flush_n <= r_flush_n - C_ONE;
            for (int i = 0; i < HOLD_DEPTH - 1; i++) begin
              r_hold[i] <= r_hold[i+1];
            end
          end
          if (r_flush_n <= C_ONE) begin
            // Payload exhausted; any remaining held bytes are trail.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_count <= C_ZERO;
          end
        end

        ST_WAIT_LP: begin
          if (lp_in) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_WAIT_LP;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data  = r_data;
  assign rx_valid = r_valid;
  assign rx_last  = r_last;
  assign rx_sot   = r_sot;
  assign rx_err   = r_err;
  assign rx_busy  = r_busy;

endmodule

// File: tb/tb_nano_dsi_data_rx.sv
// Directed testbench for nano_dsi_data_rx.
module tb_nano_dsi_data_rx;

  logic       clk;
  logic       rst;
  logic       lp_in;
  logic       hs_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_last;
  logic       rx_sot;
  logic       rx_err;
  logic       rx_busy;

  int         n_total;
  int         n_bad;
  int         n_sot;
  int         n_err;
  logic [7:0] q_data[$];
  logic       q_last[$];
  logic [7:0] exp_q[$];

  nano_dsi_data_rx #(.HOLD_DEPTH(4), .SYNC_TIMEOUT(255)) dut (
    .clk      (clk),
    .rst      (rst),
    .lp_in    (lp_in),
    .hs_in    (hs_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_last  (rx_last),
    .rx_sot   (rx_sot),
    .rx_err   (rx_err),
    .rx_busy  (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit from a negedge, record outputs just after the posedge.
  task automatic send_bit(input logic lp, input logic hs);
    lp_in = lp;
    hs_in = hs;
    @(posedge clk);
    #1;
    if (rx_valid) begin
      q_data.push_back(rx_data);
      q_last.push_back(rx_last);
    end
    if (rx_sot) n_sot++;
    if (rx_err) n_err++;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(1'b0, b[i]);
  endtask

  task automatic send_const(input int n, input logic v);
    for (int i = 0; i < n; i++) send_bit(1'b0, v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0);
  endtask

  // LP falls (IDLE cycle), zero preamble, then the sync byte.
  task automatic start_burst(input int pre);
    send_bit(1'b0, 1'b0);
    send_const(pre, 1'b0);
    send_byte(8'hB8);
  endtask

  task automatic clear_log();
    q_data.delete();
    q_last.delete();
    exp_q.delete();
    n_sot = 0;
    n_err = 0;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, 32'(q_data.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < q_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(q_data[i]), 32'(exp_q[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(q_last[i]), 32'(i == exp_q.size() - 1));
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clear_log();
    rst   = 1'b1;
    lp_in = 1'b1;
    hs_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data",  32'(rx_data),  32'd0);
    chk("rst_last",  32'(rx_last),  32'd0);
    chk("rst_sot",   32'(rx_sot),   32'd0);
    chk("rst_err",   32'(rx_err),   32'd0);
    chk("rst_busy",  32'(rx_busy),  32'd0);
    rst = 1'b0;
    idle(3);

    // Nominal burst.
    clear_log();
    start_burst(10);
    send_byte(8'h29);
    send_byte(8'h11);
    send_byte(8'h00);
    send_const(12, 1'b1);
    chk("nom_busy_data", 32'(rx_busy), 32'd1);
    idle(8);
    exp_q = '{8'h29, 8'h11, 8'h00};
    check_stream("nom");
    chk("nom_sot", 32'(n_sot), 32'd1);
    chk("nom_err", 32'(n_err), 32'd0);
    chk("nom_busy_end", 32'(rx_busy), 32'd0);

    // Long burst: 16 bytes, 7-bit trail keeps the last partial byte from completing.
    clear_log();
    start_burst(3);
    for (int b = 0; b < 16; b++) send_byte(8'(b));
    send_const(7, 1'b1);
    chk("long_mid_count", 32'(q_data.size()), 32'd12);
    idle(8);
    for (int b = 0; b < 16; b++) exp_q.push_back(8'(b));
    check_stream("long");
    chk("long_err", 32'(n_err), 32'd0);

    // Trail looks like data: 0x5A, 0xFF, then 24 zero trail bits.
    clear_log();
    start_burst(2);
    send_byte(8'h5A);
    send_byte(8'hFF);
    send_const(24, 1'b0);
    chk("amb_mid_count", 32'(q_data.size()), 32'd1);
    idle(8);
    exp_q = '{8'h5A, 8'hFF};
    check_stream("amb");
    chk("amb_err", 32'(n_err), 32'd0);

    // Empty burst.
    clear_log();
    start_burst(4);
    send_const(10, 1'b0);
    idle(8);
    chk("empty_valid", 32'(q_data.size()), 32'd0);
    chk("empty_sot", 32'(n_sot), 32'd1);
    chk("empty_err", 32'(n_err), 32'd1);
    chk("empty_busy", 32'(rx_busy), 32'd0);

    // Sync timeout after 255 hunt bits.
    clear_log();
    send_bit(1'b0, 1'b0);
    send_const(254, 1'b0);
    chk("to_err_254", 32'(n_err), 32'd0);
    send_const(1, 1'b0);
    chk("to_err_255", 32'(n_err), 32'd1);
    chk("to_busy_wait", 32'(rx_busy), 32'd1);
    send_const(45, 1'b0);
    chk("to_err_300", 32'(n_err), 32'd1);
    send_bit(1'b1, 1'b0);
    chk("to_busy_idle", 32'(rx_busy), 32'd0);
    idle(3);

    // Corrupted sync 0xB9, LP rises after 40 hunt bits.
    clear_log();
    send_bit(1'b0, 1'b0);
    send_const(8, 1'b0);
    send_byte(8'hB9);
    send_const(24, 1'b0);
    chk("bad_sync_err_pre", 32'(n_err), 32'd0);
    send_bit(1'b1, 1'b0);
    chk("bad_sync_err", 32'(n_err), 32'd1);
    chk("bad_sync_sot", 32'(n_sot), 32'd0);
    chk("bad_sync_busy", 32'(rx_busy), 32'd0);
    idle(3);

    // Framing error: last data edge at bit 13.
    clear_log();
    start_burst(4);
    send_const(13, 1'b1);
    send_const(11, 1'b0);
    idle(8);
    chk("frame_valid", 32'(q_data.size()), 32'd0);
    chk("frame_err", 32'(n_err), 32'd1);
    chk("frame_busy", 32'(rx_busy), 32'd0);

    // Reset in the middle of ST_DATA, right after a mid-burst emission.
    clear_log();
    start_burst(4);
    send_byte(8'hA5);
    for (int b = 0; b < 4; b++) send_byte(8'h3C);
    chk("mrst_valid_pre", 32'(rx_valid), 32'd1);
    chk("mrst_data_pre", 32'(rx_data), 32'hA5);
    chk("mrst_busy_pre", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(rx_valid), 32'd0);
    chk("mrst_data", 32'(rx_data), 32'd0);
    chk("mrst_last", 32'(rx_last), 32'd0);
    chk("mrst_sot", 32'(rx_sot), 32'd0);
    chk("mrst_err", 32'(rx_err), 32'd0);
    chk("mrst_busy", 32'(rx_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    chk("mrst_valid_after", 32'(q_data.size()), 32'd1);
    chk("mrst_err_after", 32'(n_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
